risac_bus_arbiter: RTL and testbench
====================================

# risac_bus_arbiter

Two-master to one-slave Avalon-MM arbiter that lets the risac core's instruction bus (read-only) and data bus (read/write) share a single memory port. Sits between the core's Avalon master ports and a unified memory or interconnect. Arbitrates one transfer at a time, forwards the winning master's command to the slave, and routes readdata and waitrequest back to the winner. A wait-state watchdog aborts transfers on a hung slave.

## Interface
- TIMEOUT_CYCLES, 256: slave wait cycles allowed per transfer before abort; 0 disables the watchdog.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- avIB_address  in  32  instruction master address.
- avIB_read  in  1  instruction read request.
- avIB_readdata  out  32  instruction read data.
- avIB_waitrequest  out  1  stall to instruction master.
- avDB_address  in  32  data master address.
- avDB_read  in  1  data read request.
- avDB_write  in  1  data write request.
- avDB_writedata  in  32  data write data.
- avDB_byteenable  in  4  data byte enables.
- avDB_readdata  out  32  data read data.
- avDB_waitrequest  out  1  stall to data master.
- avM_address  out  32  shared slave address.
- avM_read  out  1  shared slave read.
- avM_write  out  1  shared slave write.
- avM_writedata  out  32  shared slave write data.
- avM_byteenable  out  4  shared slave byte enables.
- avM_readdata  in  32  shared slave read data.
- avM_waitrequest  in  1  shared slave stall.
- oBusErr  out  1  sticky watchdog-abort flag.

## Operation
- Masters follow Avalon-MM: hold command stable until their waitrequest is low. Transfer completes in the cycle the granted master sees waitrequest low.
- IB request = avIB_read. DB request = avDB_read | avDB_write.
- State machine, registered state: IDLE, GRANT_I, GRANT_D.
- IDLE: avM_read/write = 0, avM_address = 0, avM_writedata = 0, avM_byteenable = 0. Both master waitrequests = 1. On any request, next state = winner's grant state.
- Arbitration (default): DB has fixed priority over IB.
- GRANT_I: avM_address = avIB_address, avM_read = avIB_read, avM_write = 0, avM_byteenable = 4'hF, avM_writedata = 0. avIB_waitrequest = avM_waitrequest; avDB_waitrequest = 1.
- GRANT_D: all DB command signals pass through. avDB_waitrequest = avM_waitrequest; avIB_waitrequest = 1.
- Readdata: granted master receives avM_readdata. The ungranted master, and both masters in IDLE, receive 0.
- Grant exit, to IDLE:
  - the granted request completes (avM_waitrequest = 0), or
  - the granted master drops its request (protocol violation; no slave command that cycle beyond the dropped signals).
- One-cycle IDLE bubble after every transfer. This prevents re-granting on a request that has just completed.
- Watchdog: a 16-bit counter clears on grant entry and increments each grant cycle with avM_waitrequest = 1.
  - When TIMEOUT_CYCLES != 0 and count == TIMEOUT_CYCLES: avM_read/write forced 0, granted master sees waitrequest = 0 with readdata 32'hDEADBEEF, oBusErr set, state returns to IDLE.
- oBusErr clears only on rst.

## Timing
- Reset (rst high at an edge): state = IDLE, counter = 0, oBusErr = 0, last-grant = IB. All outputs take IDLE values the next cycle.
- Reset mid-transfer abandons the transfer; the slave command drops the cycle after reset is sampled.
- Request seen in IDLE at cycle N: slave command is driven in cycle N+1.
- Zero-wait slave: completion at N+1, IDLE at N+2, next grant at N+3. Sustained throughput is one transfer per 2 cycles.
- Simultaneous IB and DB requests in IDLE are resolved by the arbitration rule. The loser's waitrequest stays 1 with no timeout toward the master.
- Waitrequest to the granted master is combinational from avM_waitrequest; all other control is registered.

## Configuration
- RISAC_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant register updates on each grant entry.
  - On a tie, the master not granted last wins.
  - The reset value is IB, so the first tie goes to DB.
  - A lone requester always wins.
- RISAC_ARB_RR_EN undefined: fixed DB priority; no last-grant register.

## Test plan
- Reset then lone IB read of 0x100, slave returns 0x12345678 with 0 waits -> avM_read high in cycle 2 after request, avIB_readdata = 0x12345678 with avIB_waitrequest = 0 in that cycle, state IDLE next cycle.
- IB read and DB write (addr 0x200, data 0xCAFEF00D, byteenable 4'b0011) asserted together -> DB granted first, write forwarded exactly, then IB granted after a one-cycle bubble. With RISAC_ARB_RR_EN, a second simultaneous pair goes to IB.
- DB read with slave waitrequest high for 5 cycles -> avDB_waitrequest high throughout, avIB_waitrequest high throughout, completion in cycle 6 of the grant.
- TIMEOUT_CYCLES = 8, slave waitrequest stuck high on IB read -> after 8 wait cycles avIB_readdata = 0xDEADBEEF, avIB_waitrequest = 0, avM_read = 0, oBusErr = 1 and stays 1 until rst.
- rst asserted during GRANT_D with waiting slave -> next cycle avM_write = 0, both master waitrequests = 1, oBusErr = 0, next request arbitrated normally.

Source files
------------

// File: rtl/risac_bus_arbiter_if.sv
// Avalon-MM bundle: instruction master (IB), data master (DB) and shared slave port (M).
// The master modport is the arbiter's view. The slave modport is the view of the core and memory around it.
interface risac_bus_arbiter_if;
  logic [31:0] avIB_address;
  logic        avIB_read;
  logic [31:0] avIB_readdata;
  logic        avIB_waitrequest;

  logic [31:0] avDB_address;
  logic        avDB_read;
  logic        avDB_write;
  logic [31:0] avDB_writedata;
  logic [3:0]  avDB_byteenable;
  logic [31:0] avDB_readdata;
  logic        avDB_waitrequest;

  logic [31:0] avM_address;
  logic        avM_read;
  logic        avM_write;
  logic [31:0] avM_writedata;
  logic [3:0]  avM_byteenable;
  logic [31:0] avM_readdata;
  logic        avM_waitrequest;

  modport master (
    input  avIB_address, avIB_read,
    output avIB_readdata, avIB_waitrequest,
    input  avDB_address, avDB_read, avDB_write, avDB_writedata, avDB_byteenable,
    output avDB_readdata, avDB_waitrequest,
    output avM_address, avM_read, avM_write, avM_writedata, avM_byteenable,
    input  avM_readdata, avM_waitrequest
  );

  modport slave (
    output avIB_address, avIB_read,
    input  avIB_readdata, avIB_waitrequest,
    output avDB_address, avDB_read, avDB_write, avDB_writedata, avDB_byteenable,
    input  avDB_readdata, avDB_waitrequest,
    input  avM_address, avM_read, avM_write, avM_writedata, avM_byteenable,
    output avM_readdata, avM_waitrequest
  );
endinterface

// File: rtl/risac_bus_arbiter.sv
// Two-master (IB read-only, DB read/write) to one-slave Avalon-MM arbiter with a wait-state watchdog.
// Fixed DB priority by default; define RISAC_ARB_RR_EN for round-robin arbitration on ties.
module risac_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  risac_bus_arbiter_if.master bus,
  output logic                oBusErr
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  localparam logic [15:0] timeoutLimit = 16'(TIMEOUT_CYCLES);
  localparam logic        watchdogEn   = (TIMEOUT_CYCLES != 0);

  state_t      state;
  state_t      stateNext;
  logic [15:0] waitCnt;
  logic        reqI;
  logic        reqD;
  logic        winD;
  logic        timeout;

  assign reqI    = bus.avIB_read;
  assign reqD    = bus.avDB_read | bus.avDB_write;
  assign timeout = watchdogEn && (state != IDLE) && (waitCnt == timeoutLimit);

`ifdef RISAC_ARB_RR_EN
  logic lastD;

  // On a tie, the master that did not win last time gets the bus.
  assign winD = reqD & (~reqI | ~lastD);

  always_ff @(posedge clk) begin
    if (rst) begin
      lastD <= 1'b0;
    end else if (state == IDLE && stateNext != IDLE) begin
      lastD <= (stateNext == GRANT_D);
    end
  end
`else
  assign winD = reqD;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= 16'd0;
      oBusErr <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE) begin
        waitCnt <= 16'd0;
      end else if (bus.avM_waitrequest) begin
        waitCnt <= waitCnt + 16'd1;
      end
      if (timeout) begin
        oBusErr <= 1'b1;
      end
    end
  end

  always_comb begin
    stateNext            = state;
    bus.avM_address      = 32'd0;
    bus.avM_read         = 1'b0;
    bus.avM_write        = 1'b0;
    bus.avM_writedata    = 32'd0;
    bus.avM_byteenable   = 4'd0;
    bus.avIB_waitrequest = 1'b1;
    bus.avDB_waitrequest = 1'b1;
    bus.avIB_readdata    = 32'd0;
    bus.avDB_readdata    = 32'd0;

    case (state)
      IDLE: begin
        if (winD) begin
          stateNext = GRANT_D;
        end else if (reqI) begin
          stateNext = GRANT_I;
        end
      end

      GRANT_I: begin
        bus.avM_address      = bus.avIB_address;
        bus.avM_read         = bus.avIB_read;
        bus.avM_byteenable   = 4'hF;
        bus.avIB_waitrequest = bus.avM_waitrequest;
        bus.avIB_readdata    = bus.avM_readdata;
        if (timeout) begin
          bus.avM_read         = 1'b0;
          bus.avIB_waitrequest = 1'b0;
          bus.avIB_readdata    = 32'hDEADBEEF;
          stateNext            = IDLE;
        end else if (!reqI || !bus.avM_waitrequest) begin
          stateNext = IDLE;
        end
      end

      GRANT_D: begin
        bus.avM_address      = bus.avDB_address;
        bus.avM_read         = bus.avDB_read;
        bus.avM_write        = bus.avDB_write;
        bus.avM_writedata    = bus.avDB_writedata;
        bus.avM_byteenable   = bus.avDB_byteenable;
        bus.avDB_waitrequest = bus.avM_waitrequest;
        bus.avDB_readdata    = bus.avM_readdata;
        if (timeout) begin
          bus.avM_read         = 1'b0;
          bus.avM_write        = 1'b0;
          bus.avDB_waitrequest = 1'b0;
          bus.avDB_readdata    = 32'hDEADBEEF;
          stateNext            = IDLE;
        end else if (!reqD || !bus.avM_waitrequest) begin
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_risac_bus_arbiter.sv
// Directed bench for risac_bus_arbiter: reset, lone read, arbitration, wait states, watchdog, mid-transfer reset.
module tb_risac_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic oBusErr;
  int   checks = 0;
  int   failures = 0;

  risac_bus_arbiter_if bus();

  risac_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .oBusErr (oBusErr)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs;
    bus.avIB_address    = 32'd0;
    bus.avIB_read       = 1'b0;
    bus.avDB_address    = 32'd0;
    bus.avDB_read       = 1'b0;
    bus.avDB_write      = 1'b0;
    bus.avDB_writedata  = 32'd0;
    bus.avDB_byteenable = 4'd0;
    bus.avM_readdata    = 32'd0;
    bus.avM_waitrequest = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (bus.avM_read !== 1'b0) begin failures++; $display("FAIL rst_mread got=%0h exp=0", bus.avM_read); end
    checks++; if (bus.avM_byteenable !== 4'h0) begin failures++; $display("FAIL rst_mbe got=%0h exp=0", bus.avM_byteenable); end
    checks++; if (bus.avIB_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_ibwait got=%0h exp=1", bus.avIB_waitrequest); end
    checks++; if (bus.avDB_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_dbwait got=%0h exp=1", bus.avDB_waitrequest); end
    checks++; if (oBusErr !== 1'b0) begin failures++; $display("FAIL rst_buserr got=%0h exp=0", oBusErr); end
    rst = 1'b0;
  endtask

  task automatic test_lone_ib;
    @(negedge clk);
    bus.avIB_address = 32'h100; bus.avIB_read = 1'b1;
    bus.avM_waitrequest = 1'b0; bus.avM_readdata = 32'h12345678;
    #1;
    checks++; if (bus.avM_read !== 1'b0) begin failures++; $display("FAIL ib_idle_mread got=%0h exp=0", bus.avM_read); end
    checks++; if (bus.avIB_waitrequest !== 1'b1) begin failures++; $display("FAIL ib_idle_wait got=%0h exp=1", bus.avIB_waitrequest); end
    @(negedge clk); #1;
    checks++; if (bus.avM_read !== 1'b1) begin failures++; $display("FAIL ib_mread got=%0h exp=1", bus.avM_read); end
    checks++; if (bus.avM_address !== 32'h100) begin failures++; $display("FAIL ib_maddr got=%0h exp=100", bus.avM_address); end
    checks++; if (bus.avM_byteenable !== 4'hF) begin failures++; $display("FAIL ib_mbe got=%0h exp=f", bus.avM_byteenable); end
    checks++; if (bus.avM_write !== 1'b0) begin failures++; $display("FAIL ib_mwrite got=%0h exp=0", bus.avM_write); end
    checks++; if (bus.avIB_waitrequest !== 1'b0) begin failures++; $display("FAIL ib_wait got=%0h exp=0", bus.avIB_waitrequest); end
    checks++; if (bus.avIB_readdata !== 32'h12345678) begin failures++; $display("FAIL ib_rdata got=%0h exp=12345678", bus.avIB_readdata); end
    checks++; if (bus.avDB_waitrequest !== 1'b1) begin failures++; $display("FAIL ib_dbwait got=%0h exp=1", bus.avDB_waitrequest); end
    checks++; if (bus.avDB_readdata !== 32'h0) begin failures++; $display("FAIL ib_dbrdata got=%0h exp=0", bus.avDB_readdata); end
    @(negedge clk);
    bus.avIB_read = 1'b0;
    #1;
    checks++; if (bus.avM_read !== 1'b0) begin failures++; $display("FAIL ib_after_mread got=%0h exp=0", bus.avM_read); end
    checks++; if (bus.avM_address !== 32'h0) begin failures++; $display("FAIL ib_after_maddr got=%0h exp=0", bus.avM_address); end
    checks++; if (bus.avIB_readdata !== 32'h0) begin failures++; $display("FAIL ib_after_rdata got=%0h exp=0", bus.avIB_readdata); end
  endtask

  task automatic test_arbitration;
    @(negedge clk);
    bus.avIB_address = 32'h104; bus.avIB_read = 1'b1;
    bus.avDB_address = 32'h200; bus.avDB_write = 1'b1;
    bus.avDB_writedata = 32'hCAFEF00D; bus.avDB_byteenable = 4'b0011;
    bus.avM_waitrequest = 1'b0; bus.avM_readdata = 32'h11112222;
    @(negedge clk); #1;
    checks++; if (bus.avM_write !== 1'b1) begin failures++; $display("FAIL arb_mwrite got=%0h exp=1", bus.avM_write); end
    checks++; if (bus.avM_read !== 1'b0) begin failures++; $display("FAIL arb_mread got=%0h exp=0", bus.avM_read); end
    checks++; if (bus.avM_address !== 32'h200) begin failures++; $display("FAIL arb_maddr got=%0h exp=200", bus.avM_address); end
    checks++; if (bus.avM_writedata !== 32'hCAFEF00D) begin failures++; $display("FAIL arb_wdata got=%0h exp=cafef00d", bus.avM_writedata); end
    checks++; if (bus.avM_byteenable !== 4'b0011) begin failures++; $display("FAIL arb_mbe got=%0h exp=3", bus.avM_byteenable); end
    checks++; if (bus.avDB_waitrequest !== 1'b0) begin failures++; $display("FAIL arb_dbwait got=%0h exp=0", bus.avDB_waitrequest); end
    checks++; if (bus.avIB_waitrequest !== 1'b1) begin failures++; $display("FAIL arb_ibwait got=%0h exp=1", bus.avIB_waitrequest); end
    checks++; if (bus.avIB_readdata !== 32'h0) begin failures++; $display("FAIL arb_ibrdata got=%0h exp=0", bus.avIB_readdata); end
    @(negedge clk);
    bus.avDB_write = 1'b0;
    #1;
    checks++; if (bus.avM_write !== 1'b0) begin failures++; $display("FAIL arb_bubble_mwrite got=%0h exp=0", bus.avM_write); end
    checks++; if (bus.avM_read !== 1'b0) begin failures++; $display("FAIL arb_bubble_mread got=%0h exp=0", bus.avM_read); end
    checks++; if (bus.avIB_waitrequest !== 1'b1) begin failures++; $display("FAIL arb_bubble_ibwait got=%0h exp=1", bus.avIB_waitrequest); end
    @(negedge clk); #1;
    checks++; if (bus.avM_read !== 1'b1) begin failures++; $display("FAIL arb_ib_mread got=%0h exp=1", bus.avM_read); end
    checks++; if (bus.avM_address !== 32'h104) begin failures++; $display("FAIL arb_ib_maddr got=%0h exp=104", bus.avM_address); end
    checks++; if (bus.avM_writedata !== 32'h0) begin failures++; $display("FAIL arb_ib_wdata got=%0h exp=0", bus.avM_writedata); end
    checks++; if (bus.avIB_readdata !== 32'h11112222) begin failures++; $display("FAIL arb_ib_rdata got=%0h exp=11112222", bus.avIB_readdata); end
    @(negedge clk);
    bus.avIB_read = 1'b0;
  endtask

  task automatic test_tie_alternation;
    logic [31:0] expAddr;
    logic        expIbWait;
`ifdef RISAC_ARB_RR_EN
    expAddr = 32'h10C; expIbWait = 1'b0;
`else
    expAddr = 32'h20C; expIbWait = 1'b1;
`endif
    @(negedge clk);
    bus.avIB_address = 32'h108; bus.avIB_read = 1'b1;
    bus.avDB_address = 32'h208; bus.avDB_read = 1'b1;
    bus.avM_waitrequest = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.avM_address !== 32'h208) begin failures++; $display("FAIL tie1_maddr got=%0h exp=208", bus.avM_address); end
    @(negedge clk);
    bus.avIB_read = 1'b0; bus.avDB_read = 1'b0;
    @(negedge clk);
    bus.avIB_address = 32'h10C; bus.avIB_read = 1'b1;
    bus.avDB_address = 32'h20C; bus.avDB_read = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.avM_address !== expAddr) begin failures++; $display("FAIL tie2_maddr got=%0h exp=%0h", bus.avM_address, expAddr); end
    checks++; if (bus.avIB_waitrequest !== expIbWait) begin failures++; $display("FAIL tie2_ibwait got=%0h exp=%0h", bus.avIB_waitrequest, expIbWait); end
    checks++; if (bus.avDB_waitrequest !== ~expIbWait) begin failures++; $display("FAIL tie2_dbwait got=%0h exp=%0h", bus.avDB_waitrequest, ~expIbWait); end
    @(negedge clk);
    bus.avIB_read = 1'b0; bus.avDB_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    @(negedge clk);
    bus.avDB_address = 32'h300; bus.avDB_read = 1'b1;
    bus.avM_waitrequest = 1'b1; bus.avM_readdata = 32'h0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); #1;
      checks++; if (bus.avDB_waitrequest !== 1'b1) begin failures++; $display("FAIL ws_dbwait cyc=%0d got=%0h exp=1", i, bus.avDB_waitrequest); end
      checks++; if (bus.avIB_waitrequest !== 1'b1) begin failures++; $display("FAIL ws_ibwait cyc=%0d got=%0h exp=1", i, bus.avIB_waitrequest); end
      checks++; if (bus.avM_read !== 1'b1) begin failures++; $display("FAIL ws_mread cyc=%0d got=%0h exp=1", i, bus.avM_read); end
    end
    @(negedge clk);
    bus.avM_waitrequest = 1'b0; bus.avM_readdata = 32'hA5A50001;
    #1;
    checks++; if (bus.avDB_waitrequest !== 1'b0) begin failures++; $display("FAIL ws_done_wait got=%0h exp=0", bus.avDB_waitrequest); end
    checks++; if (bus.avDB_readdata !== 32'hA5A50001) begin failures++; $display("FAIL ws_done_rdata got=%0h exp=a5a50001", bus.avDB_readdata); end
    @(negedge clk);
    bus.avDB_read = 1'b0;
    #1;
    checks++; if (bus.avM_read !== 1'b0) begin failures++; $display("FAIL ws_after_mread got=%0h exp=0", bus.avM_read); end
    checks++; if (bus.avDB_waitrequest !== 1'b1) begin failures++; $display("FAIL ws_after_dbwait got=%0h exp=1", bus.avDB_waitrequest); end
  endtask

  task automatic test_timeout;
    @(negedge clk);
    bus.avIB_address = 32'h400; bus.avIB_read = 1'b1;
    bus.avM_waitrequest = 1'b1; bus.avM_readdata = 32'h55555555;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      checks++; if (bus.avIB_waitrequest !== 1'b1) begin failures++; $display("FAIL to_ibwait cyc=%0d got=%0h exp=1", i, bus.avIB_waitrequest); end
      checks++; if (bus.avM_read !== 1'b1) begin failures++; $display("FAIL to_mread cyc=%0d got=%0h exp=1", i, bus.avM_read); end
      checks++; if (oBusErr !== 1'b0) begin failures++; $display("FAIL to_early_err cyc=%0d got=%0h exp=0", i, oBusErr); end
    end
    @(negedge clk); #1;
    checks++; if (bus.avIB_waitrequest !== 1'b0) begin failures++; $display("FAIL to_abort_wait got=%0h exp=0", bus.avIB_waitrequest); end
    checks++; if (bus.avIB_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL to_abort_rdata got=%0h exp=deadbeef", bus.avIB_readdata); end
    checks++; if (bus.avM_read !== 1'b0) begin failures++; $display("FAIL to_abort_mread got=%0h exp=0", bus.avM_read); end
    @(negedge clk);
    bus.avIB_read = 1'b0;
    #1;
    checks++; if (oBusErr !== 1'b1) begin failures++; $display("FAIL to_err_set got=%0h exp=1", oBusErr); end
    checks++; if (bus.avIB_waitrequest !== 1'b1) begin failures++; $display("FAIL to_idle_wait got=%0h exp=1", bus.avIB_waitrequest); end
    @(negedge clk);
    bus.avIB_address = 32'h404; bus.avIB_read = 1'b1;
    bus.avM_waitrequest = 1'b0; bus.avM_readdata = 32'h0BADF00D;
    @(negedge clk); #1;
    checks++; if (bus.avIB_readdata !== 32'h0BADF00D) begin failures++; $display("FAIL to_next_rdata got=%0h exp=badf00d", bus.avIB_readdata); end
    checks++; if (oBusErr !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%0h exp=1", oBusErr); end
    @(negedge clk);
    bus.avIB_read = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (oBusErr !== 1'b1) begin failures++; $display("FAIL to_err_hold got=%0h exp=1", oBusErr); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.avDB_address = 32'h500; bus.avDB_write = 1'b1;
    bus.avDB_writedata = 32'h00000001; bus.avDB_byteenable = 4'hF;
    bus.avM_waitrequest = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.avM_write !== 1'b1) begin failures++; $display("FAIL rm_mwrite got=%0h exp=1", bus.avM_write); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.avM_waitrequest = 1'b0;
    #1;
    checks++; if (bus.avM_write !== 1'b0) begin failures++; $display("FAIL rm_after_mwrite got=%0h exp=0", bus.avM_write); end
    checks++; if (bus.avIB_waitrequest !== 1'b1) begin failures++; $display("FAIL rm_ibwait got=%0h exp=1", bus.avIB_waitrequest); end
    checks++; if (bus.avDB_waitrequest !== 1'b1) begin failures++; $display("FAIL rm_dbwait got=%0h exp=1", bus.avDB_waitrequest); end
    checks++; if (oBusErr !== 1'b0) begin failures++; $display("FAIL rm_buserr got=%0h exp=0", oBusErr); end
    @(negedge clk); #1;
    checks++; if (bus.avM_write !== 1'b1) begin failures++; $display("FAIL rm_regrant_mwrite got=%0h exp=1", bus.avM_write); end
    checks++; if (bus.avM_address !== 32'h500) begin failures++; $display("FAIL rm_regrant_maddr got=%0h exp=500", bus.avM_address); end
    checks++; if (bus.avDB_waitrequest !== 1'b0) begin failures++; $display("FAIL rm_regrant_wait got=%0h exp=0", bus.avDB_waitrequest); end
    @(negedge clk);
    bus.avDB_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_ib();
    test_arbitration();
    test_tie_alternation();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
